sys_array_sequencer: RTL

- Control sequencer for the systolic array datapath (ARRAY_W x ARRAY_L PEs, DATA_WIDTH operands).
- On `start`, it clears the PE accumulators and generates skewed per-row A and per-column B read strobes/addresses for a K-deep inner dimension.
- It then waits out the PE pipeline and streams the result rows out under a valid/ready handshake.
- It sits between the top-level wrapper (start/param control) and the operand buffers/array.

---
 rtl/sys_array_pkg.sv | 25 ++
 rtl/sys_array_skew_gen.sv | 38 +++
 rtl/sys_array_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared configuration, state encoding and feed-length helper for the systolic array sequencer
package sys_array_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ARRAY_W    = 4;
    localparam int ARRAY_L    = 4;
    localparam int K_MAX      = 16;
    localparam int PE_LAT     = 1;
    localparam int ADDR_W     = $clog2(K_MAX);
    localparam int T_W        = $clog2(K_MAX + ARRAY_W + ARRAY_L);
    localparam int ROW_W      = $clog2(ARRAY_W);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        OUTPUT,
        DONE
    } seq_state_t;

    // Skewed feed ends when the far corner PE has seen its last operand pair
    function automatic logic [T_W-1:0] feed_len(input logic [ADDR_W:0] k);
        return T_W'(k) + T_W'(ARRAY_W + ARRAY_L - 2);
    endfunction
endpackage

// File: rtl/sys_array_skew_gen.sv
// sys_array_skew_gen: registered skewed strobe/address generation for N operand streams
module sys_array_skew_gen
    import sys_array_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [T_W-1:0]        t,
    input  logic [ADDR_W:0]       k,
    output logic [N-1:0]          valid,
    output logic [N*ADDR_W-1:0]   addr
);
    logic [N-1:0]        hit;
    logic [N*ADDR_W-1:0] d_addr;

    // Stream i is live for K counts starting at t=i; address only formed when live
    always_comb begin
        hit    = '0;
        d_addr = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = en && int'(t) >= i && int'(t) < i + int'(k);
            d_addr[i*ADDR_W +: ADDR_W] = hit[i] ? ADDR_W'(int'(t) - i) : '0;
        end
    end

    // Register the strobes so they line up with the count they were computed for
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            addr  <= '0;
        end else begin
            valid <= hit;
            addr  <= d_addr;
        end
    end
endmodule

// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer: clear/feed/flush/output control sequencer for the systolic array
module sys_array_sequencer
    import sys_array_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W:0]             k_len,
    output logic                        busy,
    output logic                        err,
    output logic                        clear_acc,
    output logic [ARRAY_W-1:0]          a_valid,
    output logic [ARRAY_W*ADDR_W-1:0]   a_addr,
    output logic [ARRAY_L-1:0]          b_valid,
    output logic [ARRAY_L*ADDR_W-1:0]   b_addr,
    output logic                        res_valid,
    output logic [ROW_W-1:0]            res_row,
    input  logic                        res_ready,
    output logic                        done
);
    seq_state_t     state, state_n;
    logic [T_W-1:0] t, t_n;
    logic [ROW_W-1:0] r;
    logic [ADDR_W:0] k_q;
    logic k_ok, accept, feed_last, flush_last, last_row, feed_n;

    // Run qualification and the shared feed/flush counter
    always_comb begin
        k_ok       = k_len != '0 && k_len <= (ADDR_W+1)'(K_MAX);
        accept     = state == IDLE && start && k_ok;
        feed_last  = t == feed_len(k_q) - T_W'(1);
        flush_last = t == T_W'(PE_LAT - 1);
        last_row   = r == ROW_W'(ARRAY_W - 1);
        t_n        = ((state == FEED && !feed_last) || (state == FLUSH && !flush_last)) ? t + T_W'(1) : '0;
        feed_n     = state_n == FEED;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state sequencing; starts are only honoured from IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? CLEAR : IDLE;
            CLEAR:   state_n = FEED;
            FEED:    state_n = feed_last ? ((PE_LAT == 0) ? OUTPUT : FLUSH) : FEED;
            FLUSH:   state_n = flush_last ? OUTPUT : FLUSH;
            OUTPUT:  state_n = (res_ready && last_row) ? DONE : OUTPUT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs decoded from state; err is the only one that reacts to start directly
    always_comb begin
        busy      = state != IDLE;
        err       = state == IDLE && start && !k_ok;
        clear_acc = state == CLEAR;
        res_valid = state == OUTPUT;
        res_row   = state == OUTPUT ? r : '0;
        done      = state == DONE;
    end

    // Feed count, result row index and latched inner dimension
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t   <= '0;
            r   <= '0;
            k_q <= '0;
        end else begin
            t <= t_n;
            r <= state == CLEAR ? '0 : (state == OUTPUT && res_ready) ? r + ROW_W'(1) : r;
            if (accept) k_q <= k_len;
        end
    end

    sys_array_skew_gen #(.N(ARRAY_W)) u_rows (
        .clk   (clk),
        .reset (reset),
        .en    (feed_n),
        .t     (t_n),
        .k     (k_q),
        .valid (a_valid),
        .addr  (a_addr)
    );

    sys_array_skew_gen #(.N(ARRAY_L)) u_cols (
        .clk   (clk),
        .reset (reset),
        .en    (feed_n),
        .t     (t_n),
        .k     (k_q),
        .valid (b_valid),
        .addr  (b_addr)
    );
endmodule
